col_drain_sched: RTL

Scheduler that empties the per-column info/data FIFO pairs filled by the partition stage into the single back FIFO that feeds the C2H feedback path. Once a batch is signalled complete, it visits columns 0..COL_MAX_SIZE-1 in fixed order. For each column it reads one info word (block length) and streams that many data words into the back FIFO under back-pressure. It then reports batch completion and byte count to the feedback block.

---
 rtl/app_pkg.sv | 32 +++
 rtl/wr_skid.sv | 68 ++++++
 rtl/col_drain_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/app_pkg.sv
// Shared types and constants for the column drain scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package app_pkg;

    // Block-length field position inside an info word; upper bits are ignored.
    localparam int LEN_WIDTH    = 16;
    localparam int INFO_LEN_LSB = 0;

    // Column FIFOs are standard mode: dout is valid one cycle after rd_en.
    localparam int FIFO_RD_LAT  = 1;

    // Words that may be outstanding between a data read and the back FIFO.
    localparam int CREDIT_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INFO_RD,
        ST_INFO_WAIT,
        ST_DATA,
        ST_NEXT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Byte count for a beat count; wraps at 2^32 like the beat counter.
    function automatic logic [31:0] beats_to_bytes(input logic [31:0] beats,
                                                   input int unsigned bytes_per_word);
        return beats * bytes_per_word;
    endfunction

endpackage

// File: rtl/wr_skid.sv
// Output stage to the back FIFO: output register O plus one-entry hold register H.
// Latency: a read issued in cycle t is written in cycle t+2 at the earliest.
// Backpressure: fifo_full stalls O; credit gates new reads so occupancy stays <= 2.
module wr_skid
    import app_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_issue,
    input  logic [DATA_WIDTH-1:0] rd_dat,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_wr_en,
    output logic [1:0]            occ,
    output logic                  credit
);

    logic                  infl;
    logic                  o_vld;
    logic                  h_vld;
    logic [DATA_WIDTH-1:0] o_dat;
    logic [DATA_WIDTH-1:0] h_dat;
    logic                  o_free;

    assign fifo_din   = o_dat;
    assign fifo_wr_en = o_vld & ~fifo_full;
    assign o_free     = ~o_vld | fifo_wr_en;

    // In-flight read + H + O; a new read is safe if what remains after this write leaves room.
    assign occ    = {1'b0, infl} + {1'b0, h_vld} + {1'b0, o_vld};
    assign credit = ({1'b0, occ} - {2'b00, fifo_wr_en}) < 3'(CREDIT_DEPTH);

    // Track the read in flight and move returning words through H/O in arrival order.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl  <= 1'b0;
            o_vld <= 1'b0;
            h_vld <= 1'b0;
            o_dat <= '0;
            h_dat <= '0;
        end else begin
            infl <= rd_issue;
            if (o_free) begin
                if (h_vld) begin
                    // H is older than the returning word, so it goes to O first.
                    o_vld <= 1'b1;
                    o_dat <= h_dat;
                    h_vld <= infl;
                    if (infl) begin
                        h_dat <= rd_dat;
                    end
                end else begin
                    o_vld <= infl;
                    if (infl) begin
                        o_dat <= rd_dat;
                    end
                end
            end else if (infl) begin
                // O is stalled; credit guarantees H is free here.
                h_vld <= 1'b1;
                h_dat <= rd_dat;
            end
        end
    end

endmodule

// File: rtl/col_drain_sched.sv
// Drains per-column info/data FIFO pairs, column 0 upward, into the single back FIFO.
// Latency: data read to back-FIFO write 2 cycles; process_done 2 cycles after last write.
// Backpressure: fifo_full stalls the output stage; data reads wait for a credit.
module col_drain_sched
    import app_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int COL_MAX_SIZE = 4,
    parameter int LEN_WIDTH    = app_pkg::LEN_WIDTH
) (
    input  logic                                 user_clk,
    input  logic                                 user_rst,
    input  logic                                 partition_done,
    output logic [COL_MAX_SIZE-1:0]              info_rd_en,
    input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0]   info_dout,
    input  logic [COL_MAX_SIZE-1:0]              info_empty,
    output logic [COL_MAX_SIZE-1:0]              data_rd_en,
    input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0]   data_dout,
    input  logic [COL_MAX_SIZE-1:0]              data_empty,
    output logic [DATA_WIDTH-1:0]                fifo_din,
    output logic                                 fifo_wr_en,
    input  logic                                 fifo_full,
    output logic                                 process_done,
    output logic [31:0]                          data_len
);

    localparam int CW = (COL_MAX_SIZE > 1) ? $clog2(COL_MAX_SIZE) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(COL_MAX_SIZE - 1);

    state_t                state;
    state_t                nxt;
    logic [CW-1:0]         col;
    logic [LEN_WIDTH-1:0]  rem;
    logic [LEN_WIDTH-1:0]  info_len;
    logic [DATA_WIDTH-1:0] data_cur;
    logic [31:0]           beats;
    logic [31:0]           len_q;
    logic                  pend;
    logic                  rd_issue;
    logic [1:0]            occ;
    logic                  credit;
    logic                  info_unused;

    // Only the length field of an info word matters.
    assign info_unused = ^info_dout;

    // Column mux. The data word returns while col still points at the column
    // it was read from: col only advances in NEXT, a cycle after the last read.
    assign info_len = info_dout[int'(col)*DATA_WIDTH + INFO_LEN_LSB +: LEN_WIDTH];
    assign data_cur = data_dout[int'(col)*DATA_WIDTH +: DATA_WIDTH];
    assign rd_issue = |data_rd_en;

    assign process_done = (state == ST_DONE);
    assign data_len     = len_q;

    wr_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (user_clk),
        .rst        (user_rst),
        .rd_issue   (rd_issue),
        .rd_dat     (data_cur),
        .fifo_full  (fifo_full),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .occ        (occ),
        .credit     (credit)
    );

    // Next-state and read strobes; at most one strobe per cycle by construction.
    always_comb begin
        nxt        = state;
        info_rd_en = '0;
        data_rd_en = '0;
        case (state)
            ST_IDLE: begin
                if (pend) begin
                    nxt = ST_INFO_RD;
                end
            end
            ST_INFO_RD: begin
                if (!info_empty[col]) begin
                    info_rd_en[col] = 1'b1;
                    nxt             = ST_INFO_WAIT;
                end
            end
            ST_INFO_WAIT: begin
                nxt = (info_len == '0) ? ST_NEXT : ST_DATA;
            end
            ST_DATA: begin
                if (!data_empty[col] && credit) begin
                    data_rd_en[col] = 1'b1;
                    if (rem == LEN_WIDTH'(1)) begin
                        nxt = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                nxt = (col == LAST_COL) ? ST_DRAIN : ST_INFO_RD;
            end
            ST_DRAIN: begin
                if (occ == 2'd0) begin
                    nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                nxt = ST_IDLE;
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Sticky batch request; a pulse seen mid-batch queues the next batch.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            pend <= 1'b0;
        end else begin
            pend <= partition_done | (pend & (state != ST_IDLE));
        end
    end

    // Column index and remaining-beat count for the column being drained.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            col <= '0;
            rem <= '0;
        end else begin
            case (state)
                ST_IDLE:      col <= '0;
                ST_INFO_WAIT: rem <= info_len;
                ST_DATA:      if (rd_issue) rem <= rem - LEN_WIDTH'(1);
                ST_NEXT:      if (col != LAST_COL) col <= col + CW'(1);
                default:      ;
            endcase
        end
    end

    // Beat count per batch and the byte count reported when the batch finishes.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            beats <= '0;
            len_q <= '0;
        end else begin
            if (state == ST_IDLE) begin
                beats <= '0;
            end else if (fifo_wr_en) begin
                beats <= beats + 32'd1;
            end
            // occ is zero on this transition, so beats is final.
            if (state == ST_DRAIN && nxt == ST_DONE) begin
                len_q <= beats_to_bytes(beats, DATA_WIDTH / 8);
            end
        end
    end

endmodule
